// File: rtl/xbar_cfg_pkg.sv
// Shared constants, state type and selector range check for the crossbar
// configuration loader. The optional XBAR_CFG_CRC_EN macro adds one trailing
// CRC-8 word to each load.
package xbar_cfg_pkg;

  localparam int NUM_IN    = 17;
  localparam int NUM_OUT   = 20;
  localparam int SEL_W     = 5;
  localparam int WORD_W    = 8;
  localparam int CFG_W     = NUM_OUT * SEL_W;
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;

  localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef XBAR_CFG_CRC_EN
  localparam int LOAD_WORDS = NUM_WORDS + 1;
`else
  localparam int LOAD_WORDS = NUM_WORDS;
`endif

  localparam int CNT_W = $clog2(LOAD_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_e;

  // True when every selector field addresses an existing crossbar input.
  function automatic logic cfg_legal(input logic [CFG_W-1:0] cfg);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cfg[k*SEL_W +: SEL_W] >= SEL_W'(NUM_IN)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/xbar_cfg_loader_if.sv
// Word-stream handshake and status signals between the configuration source
// and the loader. The source uses the master modport, the loader the slave.
interface xbar_cfg_loader_if;
  import xbar_cfg_pkg::*;

  logic              io_cfg_start;
  logic              io_cfg_valid;
  logic [WORD_W-1:0] io_cfg_data;
  logic              io_cfg_ready;
  logic              io_cfg_busy;
  logic              io_cfg_done;
  logic              io_cfg_error;

  modport master (
    output io_cfg_start, io_cfg_valid, io_cfg_data,
    input  io_cfg_ready, io_cfg_busy, io_cfg_done, io_cfg_error
  );

  modport slave (
    input  io_cfg_start, io_cfg_valid, io_cfg_data,
    output io_cfg_ready, io_cfg_busy, io_cfg_done, io_cfg_error
  );

endinterface

// File: rtl/xbar_cfg_crc8.sv
// CRC-8 accumulator: each enabled cycle folds one whole stream word into the
// running CRC, MSB first. Instantiated only when XBAR_CFG_CRC_EN is defined.
module xbar_cfg_crc8
  import xbar_cfg_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [7:0]        crc_o
);

  logic [7:0] crc_q;

  function automatic logic [7:0] crc_step(input logic [7:0]        crc,
                                          input logic [DATA_W-1:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? CRC8_POLY : 8'h00);
    end
    return c;
  endfunction

  // Running CRC register, cleared at every (re)start of a load.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples the pre-edge values of its neighbours.
    if (reset || clr_i) crc_q <= 8'h00;
    else if (en_i)      crc_q <= crc_step(crc_q, data_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/xbar_cfg_loader.sv
// Crossbar configuration loader: assembles the selector vector from a word
// stream into a shadow register, range-checks it, then commits it atomically.
// Define XBAR_CFG_CRC_EN to require a trailing CRC-8 word on every load.
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  xbar_cfg_loader_if.slave       cfg,
  output logic [CFG_W-1:0]       io_mux_configs
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] mux_q, mux_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             word_hs;
  logic             load_ok;

  // A word is taken only in LOAD, and a same-cycle restart drops it.
  assign word_hs = cfg.io_cfg_valid && (state_q == LOAD) && !cfg.io_cfg_start;

`ifdef XBAR_CFG_CRC_EN
  logic [7:0] crc_calc;
  logic [7:0] crc_word_q;
  logic       crc_clr;
  logic       crc_en;

  assign crc_clr = cfg.io_cfg_start && (state_q != CHECK);
  assign crc_en  = word_hs && (cnt_q < CNT_W'(NUM_WORDS));

  xbar_cfg_crc8 #(.DATA_W(WORD_W)) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (cfg.io_cfg_data),
    .crc_o  (crc_calc)
  );

  // Capture the transmitted CRC word (low 8 bits) for comparison in CHECK.
  always_ff @(posedge clk) begin
    if (reset)                                           crc_word_q <= 8'h00;
    else if (word_hs && (cnt_q == CNT_W'(NUM_WORDS)))    crc_word_q <= cfg.io_cfg_data[7:0];
  end

  assign load_ok = cfg_legal(shadow_q) && (crc_word_q == crc_calc);
`else
  assign load_ok = cfg_legal(shadow_q);
`endif

  // State, counter, shadow and active-configuration registers.
  always_ff @(posedge clk) begin
    // NOTE: the shadow is reset like any other register; it is flip-flops,
    // not a RAM, and a defined value keeps restarts and reset deterministic.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mux_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mux_q    <= mux_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic: load words, check the shadow, commit or flag an error.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mux_d    = mux_q;
    done_d   = 1'b0;
    error_d  = error_q;

    unique case (state_q)
      IDLE: begin
        if (cfg.io_cfg_start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          error_d  = 1'b0;
        end
      end
      LOAD: begin
        if (cfg.io_cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (word_hs) begin
          // Padding bits of the last word, and the CRC word, fall beyond CFG_W.
          for (int b = 0; b < WORD_W; b++) begin
            if ((int'(cnt_q) * WORD_W + b) < CFG_W)
              shadow_d[int'(cnt_q) * WORD_W + b] = cfg.io_cfg_data[b];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (load_ok) begin
          mux_d  = shadow_q;
          done_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg.io_cfg_ready = (state_q == LOAD);
  assign cfg.io_cfg_busy  = (state_q != IDLE);
  assign cfg.io_cfg_done  = done_q;
  assign cfg.io_cfg_error = error_q;
  assign io_mux_configs   = mux_q;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Self-checking bench for xbar_cfg_loader: a word-queue reference model is
// compared against the DUT outputs on every cycle, plus directed checks.
// Build with +define+XBAR_CFG_CRC_EN to exercise the CRC variant.
module tb_xbar_cfg_loader;
  import xbar_cfg_pkg::*;

  localparam int PAD_W = NUM_WORDS * WORD_W;
`ifdef XBAR_CFG_CRC_EN
  localparam int  TB_LOAD_WORDS = NUM_WORDS + 1;
  localparam bit  CRC_ON        = 1'b1;
`else
  localparam int  TB_LOAD_WORDS = NUM_WORDS;
  localparam bit  CRC_ON        = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [CFG_W-1:0] mux;

  always #5 clk = ~clk;

  xbar_cfg_loader_if cfg_if ();

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .cfg            (cfg_if),
    .io_mux_configs (mux)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [CFG_W-1:0] act,
                       input logic [CFG_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] crc8_of(input logic [7:0] w[$], input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (c[7] ^ w[i][b]) c = (c << 1) ^ 8'h07;
        else                c = c << 1;
      end
    end
    return c;
  endfunction

  function automatic logic [CFG_W-1:0] words_to_cfg(input logic [7:0] w[$]);
    logic [PAD_W-1:0] flat;
    flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) flat[i*WORD_W +: WORD_W] = w[i];
    return flat[CFG_W-1:0];
  endfunction

  function automatic bit fields_ok(input logic [CFG_W-1:0] c);
    for (int k = 0; k < NUM_OUT; k++)
      if (int'(c[k*SEL_W +: SEL_W]) >= NUM_IN) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]       m_words[$];
  bit               m_loading, m_check, m_done, m_error, m_live;
  logic [CFG_W-1:0] m_cfg;

  initial begin
    bit nd;
    bit ok;
    logic [CFG_W-1:0] c;
    m_live = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_loading = 0; m_check = 0; m_done = 0; m_error = 0;
        m_cfg = '0; m_words.delete(); m_live = 1'b1;
      end else begin
        nd = 1'b0;
        if (m_check) begin
          c  = words_to_cfg(m_words);
          ok = fields_ok(c);
          if (CRC_ON) ok = ok && (m_words[NUM_WORDS] == crc8_of(m_words, NUM_WORDS));
          if (ok) begin m_cfg = c; nd = 1'b1; end
          else    m_error = 1'b1;
          m_check = 1'b0;
          m_words.delete();
        end else if (m_loading) begin
          if (cfg_if.io_cfg_start) m_words.delete();
          else if (cfg_if.io_cfg_valid) begin
            m_words.push_back(cfg_if.io_cfg_data);
            if (m_words.size() == TB_LOAD_WORDS) begin
              m_loading = 1'b0;
              m_check   = 1'b1;
            end
          end
        end else if (cfg_if.io_cfg_start) begin
          m_loading = 1'b1;
          m_words.delete();
          m_error = 1'b0;
        end
        m_done = nd;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("mux",   mux,                 m_cfg);
      check("ready", cfg_if.io_cfg_ready, m_loading);
      check("busy",  cfg_if.io_cfg_busy,  m_loading || m_check);
      check("done",  cfg_if.io_cfg_done,  m_done);
      check("error", cfg_if.io_cfg_error, m_error);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [7:0] w, input int max_bubble);
    int nb;
    nb = (max_bubble > 0) ? $urandom_range(max_bubble, 0) : 0;
    repeat (nb) begin
      cfg_if.io_cfg_valid = 1'b0;
      cfg_if.io_cfg_data  = 8'($urandom);
      @(negedge clk);
    end
    cfg_if.io_cfg_valid = 1'b1;
    cfg_if.io_cfg_data  = w;
    for (int t = 0; t < 40; t++) begin
      if (cfg_if.io_cfg_ready) begin
        @(negedge clk);
        cfg_if.io_cfg_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL hs_timeout: ready never rose at %0t", $time);
    cfg_if.io_cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_if.io_cfg_start = 1'b1;
    @(negedge clk);
    cfg_if.io_cfg_start = 1'b0;
  endtask

  // Stream one configuration (random padding bits, optional CRC word).
  task automatic send_cfg(input logic [CFG_W-1:0] c, input int max_bubble,
                          input logic [7:0] crc_xor);
    logic [PAD_W-1:0] flat;
    logic [7:0]       q[$];
    flat = '0;
    flat[CFG_W-1:0] = c;
    for (int b = CFG_W; b < PAD_W; b++) flat[b] = 1'($urandom_range(1, 0));
    for (int i = 0; i < NUM_WORDS; i++) q.push_back(flat[i*WORD_W +: WORD_W]);
    if (CRC_ON) q.push_back(crc8_of(q, NUM_WORDS) ^ crc_xor);
    foreach (q[i]) send_word(q[i], max_bubble);
  endtask

  task automatic load_cfg(input logic [CFG_W-1:0] c, input int max_bubble,
                          input logic [7:0] crc_xor);
    pulse_start();
    send_cfg(c, max_bubble, crc_xor);
  endtask

  function automatic logic [CFG_W-1:0] rand_cfg(input bit legal);
    logic [CFG_W-1:0] c;
    for (int k = 0; k < NUM_OUT; k++) c[k*SEL_W +: SEL_W] = SEL_W'($urandom_range(NUM_IN-1, 0));
    if (!legal) c[$urandom_range(NUM_OUT-1, 0)*SEL_W +: SEL_W] = SEL_W'($urandom_range(31, NUM_IN));
    return c;
  endfunction

  logic [CFG_W-1:0] cfg_a, cfg_b, cfg_r, cfg_d;
  logic [7:0]       pin_q[$];

  initial begin
    bit legal;
    cfg_if.io_cfg_start = 1'b0;
    cfg_if.io_cfg_valid = 1'b0;
    cfg_if.io_cfg_data  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mux",   mux,                 '0);
    check("rst_ready", cfg_if.io_cfg_ready, 0);
    check("rst_busy",  cfg_if.io_cfg_busy,  0);
    check("rst_done",  cfg_if.io_cfg_done,  0);
    check("rst_error", cfg_if.io_cfg_error, 0);
    reset = 1'b0;
    @(negedge clk);

    // Model pin: standard CRC-8 check value of "123456789".
    for (int i = 0; i < 9; i++) pin_q.push_back(8'h31 + 8'(i));
    check("crc_model_pin", crc8_of(pin_q, 9), 8'hF4);

    // Selector k = k mod 17, no bubbles.
    for (int k = 0; k < NUM_OUT; k++) cfg_a[k*SEL_W +: SEL_W] = SEL_W'(k % NUM_IN);
    load_cfg(cfg_a, 0, 8'h00);
    check("check_ready", cfg_if.io_cfg_ready, 0);
    check("check_busy",  cfg_if.io_cfg_busy,  1);
    check("check_done",  cfg_if.io_cfg_done,  0);
    @(negedge clk);
    check("a_done",    cfg_if.io_cfg_done, 1);
    check("a_field17", mux[17*SEL_W +: SEL_W], 0);
    check("a_field19", mux[19*SEL_W +: SEL_W], 2);
    check("a_field5",  mux[5*SEL_W +: SEL_W],  5);
    check("a_mux",     mux, cfg_a);
    @(negedge clk);
    check("a_done_pulse", cfg_if.io_cfg_done, 0);

    // Field 3 illegal: rejected, prior configuration kept.
    cfg_b = cfg_a;
    cfg_b[3*SEL_W +: SEL_W] = 5'd20;
    load_cfg(cfg_b, 0, 8'h00);
    @(negedge clk);
    check("b_error", cfg_if.io_cfg_error, 1);
    check("b_done",  cfg_if.io_cfg_done,  0);
    check("b_mux",   mux, cfg_a);

    // Random loads with bubbles and valid words offered while idle.
    for (int it = 0; it < 10; it++) begin
      legal = ($urandom_range(3, 0) != 0);
      cfg_r = rand_cfg(legal);
      repeat ($urandom_range(3, 1)) begin
        cfg_if.io_cfg_valid = 1'b1;
        cfg_if.io_cfg_data  = 8'($urandom);
        @(negedge clk);
      end
      cfg_if.io_cfg_valid = 1'b0;
      load_cfg(cfg_r, 3, 8'h00);
      @(negedge clk);
      if (legal) check("rand_mux", mux, cfg_r);
      check("rand_error", cfg_if.io_cfg_error, !legal);
    end

    // Restart after 6 words; the same-cycle word is dropped.
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(8'($urandom), 1);
    cfg_if.io_cfg_start = 1'b1;
    cfg_if.io_cfg_valid = 1'b1;
    cfg_if.io_cfg_data  = 8'hFF;
    @(negedge clk);
    cfg_if.io_cfg_start = 1'b0;
    cfg_if.io_cfg_valid = 1'b0;
    cfg_d = rand_cfg(1'b1);
    send_cfg(cfg_d, 1, 8'h00);
    @(negedge clk);
    check("restart_done", cfg_if.io_cfg_done, 1);
    check("restart_mux",  mux, cfg_d);

    // Reset after 7 words, then a clean load.
    pulse_start();
    for (int i = 0; i < 7; i++) send_word(8'($urandom), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_mux",  mux, '0);
    check("midrst_busy", cfg_if.io_cfg_busy, 0);
    @(negedge clk);
    load_cfg(cfg_a, 0, 8'h00);
    @(negedge clk);
    check("postrst_mux", mux, cfg_a);

`ifdef XBAR_CFG_CRC_EN
    // Corrupted CRC word is rejected; the correct one commits.
    cfg_r = rand_cfg(1'b1);
    load_cfg(cfg_r, 0, 8'h01);
    @(negedge clk);
    check("crc_bad_error", cfg_if.io_cfg_error, 1);
    check("crc_bad_mux",   mux, cfg_a);
    load_cfg(cfg_r, 0, 8'h00);
    @(negedge clk);
    check("crc_ok_done", cfg_if.io_cfg_done, 1);
    check("crc_ok_mux",  mux, cfg_r);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_cmp++; n_bad++;
    $display("FAIL global_timeout: bench did not finish at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
